// File: rtl/recip_seq_div_if.sv
// rtl/recip_seq_div_if.sv - launch/result bundle between the line sequencer and the reciprocal unit
interface recip_seq_div_if #(
  parameter int DEN_W = 10,
  parameter int OUT_W = 11
);
  logic             start;
  logic [DEN_W-1:0] denom;
  logic [OUT_W-1:0] recip;
  logic             busy;
  logic             done;

  modport master (output start, denom, input recip, busy, done);
  modport slave  (input start, denom, output recip, busy, done);
endinterface

// File: rtl/recip_seq_div.sv
// rtl/recip_seq_div.sv - bit-serial floor(2^NUM_W/denom), saturated to OUT_W bits
// Optional macro RECIP_ROUND_EN switches the final result to round-to-nearest.
module recip_seq_div #(
  parameter int NUM_W = 16,
  parameter int DEN_W = 10,
  parameter int OUT_W = 11
) (
  input  logic           clk48,
  input  logic           rst,
  recip_seq_div_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_W);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_W - 1);
  localparam logic [NUM_W:0]   SAT_MAX  = (NUM_W+1)'((64'd1 << OUT_W) - 64'd1);

  logic [0:0]       state;
  logic [DEN_W-1:0] d_reg;
  logic             d_small;
  logic [DEN_W:0]   rem;
  logic [NUM_W-1:0] quo;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] recip_q;
  logic             busy_q;
  logic             done_q;

  logic             launch;
  logic [DEN_W-1:0] step_d;
  logic [DEN_W:0]   step_r;
  logic [DEN_W+1:0] trial;
  logic [DEN_W+1:0] diff;
  logic             step_bit;
  logic [DEN_W:0]   rem_next;
  logic [NUM_W-1:0] quo_next;
  logic [NUM_W:0]   quo_final;
  logic [OUT_W-1:0] recip_final;
`ifdef RECIP_ROUND_EN
  logic             round_up;
`endif

  // A launch reuses the same restoring step, seeded with remainder 1 and the incoming divisor.
  always_comb begin
    launch   = bus.start;
    step_d   = launch ? bus.denom : d_reg;
    step_r   = launch ? (DEN_W+1)'(1) : rem;
    trial    = {step_r, 1'b0};
    diff     = trial - {2'b00, step_d};
    step_bit = (trial >= {2'b00, step_d});
    rem_next = step_bit ? diff[DEN_W:0] : trial[DEN_W:0];
    quo_next = launch ? {{(NUM_W-1){1'b0}}, step_bit} : {quo[NUM_W-2:0], step_bit};
`ifdef RECIP_ROUND_EN
    round_up  = ({rem_next, 1'b0} >= {2'b00, d_reg});
    quo_final = {1'b0, quo_next} + (NUM_W+1)'(round_up);
`else
    quo_final = {1'b0, quo_next};
`endif
    recip_final = (d_small || (quo_final > SAT_MAX)) ? {OUT_W{1'b1}} : quo_final[OUT_W-1:0];
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state   <= S_IDLE;
      d_reg   <= '0;
      d_small <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      recip_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A start always wins, including over the final iteration of a run in progress.
      if (launch) begin
        d_reg   <= bus.denom;
        d_small <= (bus.denom <= DEN_W'(1));
        rem     <= rem_next;
        quo     <= quo_next;
        cnt     <= CNT_W'(1);
        busy_q  <= 1'b1;
        state   <= S_RUN;
      end else if (state == S_RUN) begin
        rem <= rem_next;
        quo <= quo_next;
        if (cnt == LAST_CNT) begin
          recip_q <= recip_final;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt     <= '0;
          state   <= S_IDLE;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.recip = recip_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_recip_seq_div.sv
// tb/tb_recip_seq_div.sv - directed checks of recip_seq_div latency, saturation, restart and reset
module tb_recip_seq_div;
  logic clk48;
  logic rst;
  int   n_assert;
  int   n_fail;

  recip_seq_div_if #(.DEN_W(10), .OUT_W(11)) bus ();

  recip_seq_div #(.NUM_W(16), .DEN_W(10), .OUT_W(11)) dut (
    .clk48 (clk48),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk48 = 1'b0;
  always #5 clk48 = ~clk48;

`ifdef RECIP_ROUND_EN
  localparam int EXP_97  = 676;
  localparam int EXP_200 = 328;
  int stream_exp[8] = '{1928, 1872, 1024, 1008, 512, 328, 256, 235};
`else
  localparam int EXP_97  = 675;
  localparam int EXP_200 = 327;
  int stream_exp[8] = '{1927, 1872, 1024, 1008, 512, 327, 256, 234};
`endif
  int stream_d[8] = '{34, 35, 64, 65, 128, 200, 256, 279};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [9:0] d);
    bus.start = 1'b1;
    bus.denom = d;
    @(posedge clk48);
    @(negedge clk48);
    bus.start = 1'b0;
  endtask

  task automatic observe(input logic [31:0] prev, output int done_at, output int done_cnt,
                         output int busy_cnt, output int early);
    done_at = -1; done_cnt = 0; busy_cnt = 0; early = 0;
    for (int j = 0; j <= 20; j++) begin
      if (j > 0) begin
        @(posedge clk48);
        @(negedge clk48);
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (done_cnt == 0 && bus.recip !== prev[10:0]) early++;
    end
  endtask

  task automatic run_div(input string tag, input logic [9:0] d, input int exp);
    logic [31:0] prev;
    int done_at, done_cnt, busy_cnt, early;
    prev = 32'(bus.recip);
    launch(d);
    observe(prev, done_at, done_cnt, busy_cnt, early);
    chk({tag, "_latency"}, done_at, 15);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_busy_cycles"}, busy_cnt, 15);
    chk({tag, "_recip_hold"}, early, 0);
    chk({tag, "_recip"}, 32'(bus.recip), exp);
  endtask

  initial begin
    logic [31:0] prev;
    int done_at, done_cnt, busy_cnt, early, pre_done;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.denom = '0;
    repeat (3) @(posedge clk48);
    @(negedge clk48);
    chk("reset_recip", 32'(bus.recip), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    rst = 1'b0;
    @(negedge clk48);

    run_div("d100", 10'd100, 655);
    run_div("d97", 10'd97, EXP_97);
    run_div("d3", 10'd3, 2047);
    run_div("d0", 10'd0, 2047);
    run_div("d1023", 10'd1023, 64);

    // Restart five cycles into a run
    prev = 32'(bus.recip);
    pre_done = 0;
    launch(10'd100);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin
        @(posedge clk48);
        @(negedge clk48);
      end
      if (bus.done === 1'b1) pre_done++;
    end
    launch(10'd200);
    observe(prev, done_at, done_cnt, busy_cnt, early);
    chk("restart_no_early_done", pre_done, 0);
    chk("restart_latency", done_at, 15);
    chk("restart_done_count", done_cnt, 1);
    chk("restart_recip_hold", early, 0);
    chk("restart_recip", 32'(bus.recip), EXP_200);

    // Reset at iteration 8, with a start asserted alongside it
    launch(10'd100);
    repeat (7) begin
      @(posedge clk48);
      @(negedge clk48);
    end
    rst = 1'b1;
    bus.start = 1'b1;
    bus.denom = 10'd5;
    @(posedge clk48);
    @(negedge clk48);
    chk("midreset_recip", 32'(bus.recip), 0);
    chk("midreset_busy", 32'(bus.busy), 0);
    chk("midreset_done", 32'(bus.done), 0);
    rst = 1'b0;
    bus.start = 1'b0;
    observe(32'd0, done_at, done_cnt, busy_cnt, early);
    chk("midreset_no_done", done_cnt, 0);
    chk("midreset_no_busy", busy_cnt, 0);
    run_div("post_reset_d97", 10'd97, EXP_97);

    // Line-rate stream, one start per 1525-cycle line
    for (int i = 0; i < 8; i++) begin
      logic [10:0] last;
      int dcnt, stray;
      dcnt = 0;
      stray = 0;
      launch(10'(stream_d[i]));
      last = bus.recip;
      for (int c = 0; c < 1524; c++) begin
        @(posedge clk48);
        @(negedge clk48);
        if (bus.done === 1'b1) dcnt++;
        if (bus.recip !== last && bus.done !== 1'b1) stray++;
        last = bus.recip;
      end
      chk($sformatf("line%0d_done_count", i), dcnt, 1);
      chk($sformatf("line%0d_stable", i), stray, 0);
      chk($sformatf("line%0d_recip", i), 32'(bus.recip), stream_exp[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
